// File: rtl/wb_thr_pkg.sv
// Shared constants for the Wishbone threshold register bank.
package wb_thr_pkg;

  // CTRL register bit positions
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_IMM    = 1;

  // Default width of the shadow-backed read-back field
  localparam int DEF_LOW_W   = 16;

  // CTRL sits directly after the last channel word
  function automatic int ctrl_adr(input int n_chan);
    return n_chan;
  endfunction

endpackage

// File: rtl/wb_thr_chan.sv
// One threshold channel: shadow/active pair, dirty flag and update pulse.
module wb_thr_chan (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_wr,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_dat,
  input  logic        i_imm,
  input  logic        i_commit,
  output logic [31:0] o_shadow,
  output logic [31:0] o_active,
  output logic        o_upd
);

  logic [31:0] r_shadow, r_active;
  logic        r_dirty, r_upd;
  logic [31:0] w_merged;

  // Byte-lane merge of write data into the current shadow
  always_comb begin
    w_merged = r_shadow;
    for (int b = 0; b < 4; b++)
      if (i_sel[b]) w_merged[8*b +: 8] = i_dat[8*b +: 8];
  end

  // Shadow/active/dirty update; a channel write and a commit never coincide
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shadow <= '0;
      r_active <= '0;
      r_dirty  <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (i_wr) begin
        r_shadow <= w_merged;
        if (i_imm) begin
          r_active <= w_merged;
          r_upd    <= 1'b1;
          r_dirty  <= 1'b0;
        end else begin
          r_dirty  <= 1'b1;
        end
      end else if (i_commit && r_dirty) begin
        r_active <= r_shadow;
        r_upd    <= 1'b1;
        r_dirty  <= 1'b0;
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;
  assign o_upd    = r_upd;

endmodule

// File: rtl/wb_thr_bank.sv
// Wishbone slave front end, address decode and read mux for N_CHAN threshold channels.
module wb_thr_bank
  import wb_thr_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int LOW_W  = DEF_LOW_W,
  parameter int ADR_W  = $clog2(N_CHAN + 1)
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADR_W-1:0]         wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_stall_o,
  output logic                     wb_rty_o,
  output logic [31:0]              wb_dat_o,
  input  logic [N_CHAN-1:0][31:0]  thr_i,
  output logic [N_CHAN-1:0][31:0]  thr_o,
  output logic [N_CHAN-1:0]        thr_upd_o
);

  localparam logic [ADR_W-1:0] CTRL_ADR = ADR_W'(ctrl_adr(N_CHAN));
  localparam logic [31:0]      LOW_MASK = (32'h1 << LOW_W) - 32'h1;

  logic              r_rip, r_wip, r_ack, r_err, r_imm, r_wr_vld;
  logic [31:0]       r_dat, r_wr_dat;
  logic [3:0]        r_wr_sel;
  logic [ADR_W-1:0]  r_wr_adr;

  logic                     w_en, w_rd_req, w_wr_req, w_rd_ok, w_wr_ok;
  logic                     w_ctrl_lane, w_commit;
  logic [31:0]              w_rd_dat;
  logic [N_CHAN-1:0]        w_chan_wr;
  logic [N_CHAN-1:0][31:0]  w_shadow;

  assign w_en     = wb_cyc_i & wb_stb_i;
  assign w_rd_req = w_en & ~wb_we_i & ~r_rip;
  assign w_wr_req = w_en &  wb_we_i & ~r_wip;
  assign w_rd_ok  = (wb_adr_i <= CTRL_ADR);
  assign w_wr_ok  = (r_wr_adr <= CTRL_ADR);

  // CTRL takes effect only with byte lane 0; raising IMM flushes pending channels
  assign w_ctrl_lane = r_wr_vld & (r_wr_adr == CTRL_ADR) & r_wr_sel[0];
  assign w_commit    = w_ctrl_lane &
                       (r_wr_dat[CTRL_COMMIT] | (r_wr_dat[CTRL_IMM] & ~r_imm));

  // Read mux: low field from shadow, upper field from live channel status
  always_comb begin
    w_rd_dat = '0;
    for (int k = 0; k < N_CHAN; k++)
      if (wb_adr_i == ADR_W'(k))
        w_rd_dat = (w_shadow[k] & LOW_MASK) | (thr_i[k] & ~LOW_MASK);
    if (wb_adr_i == CTRL_ADR) w_rd_dat[CTRL_IMM] = r_imm;
  end

  // Bus sequencing: read terminates one cycle after request, write two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rip    <= 1'b0;
      r_wip    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_wr_vld <= 1'b0;
      r_wr_adr <= '0;
      r_wr_sel <= '0;
      r_wr_dat <= '0;
      r_imm    <= 1'b1;
    end else begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_wr_vld <= w_wr_req;
      if (r_ack | r_err) begin
        r_rip <= 1'b0;
        r_wip <= 1'b0;
      end
      if (w_rd_req) begin
        r_rip <= 1'b1;
        r_ack <= w_rd_ok;
        r_err <= ~w_rd_ok;
        r_dat <= w_rd_dat;
      end
      if (w_wr_req) begin
        r_wip    <= 1'b1;
        r_wr_adr <= wb_adr_i;
        r_wr_sel <= wb_sel_i;
        r_wr_dat <= wb_dat_i;
      end
      if (r_wr_vld) begin
        r_ack <= w_wr_ok;
        r_err <= ~w_wr_ok;
      end
      if (w_ctrl_lane) r_imm <= r_wr_dat[CTRL_IMM];
    end
  end

  for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
    assign w_chan_wr[k] = r_wr_vld & (r_wr_adr == ADR_W'(k));
    wb_thr_chan u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_wr     (w_chan_wr[k]),
      .i_sel    (r_wr_sel),
      .i_dat    (r_wr_dat),
      .i_imm    (r_imm),
      .i_commit (w_commit),
      .o_shadow (w_shadow[k]),
      .o_active (thr_o[k]),
      .o_upd    (thr_upd_o[k])
    );
  end

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_stall_o = ~(r_ack | r_err) & w_en;
  assign wb_rty_o   = 1'b0;
  assign wb_dat_o   = r_dat;

endmodule

// File: tb/tb_wb_thr_bank.sv
// Directed bench for wb_thr_bank (N_CHAN=4, LOW_W=16).
module tb_wb_thr_bank;

  logic             clk = 1'b0;
  logic             rst;
  logic             cyc, stb, we;
  logic [2:0]       adr;
  logic [3:0]       sel;
  logic [31:0]      dat;
  logic             ack, err, stall, rty;
  logic [31:0]      dout;
  logic [3:0][31:0] thr_i, thr_o;
  logic [3:0]       upd;

  int n_tot = 0;
  int n_bad = 0;

  // values captured by the bus tasks
  logic        s_ack, s_err, s_early, s_stall0, s_tail;
  logic [31:0] s_dat;
  logic [3:0]  s_upd, s_upd3;

  always #5 clk = ~clk;

  wb_thr_bank #(.N_CHAN(4), .LOW_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_sel_i   (sel),
    .wb_dat_i   (dat),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_stall_o (stall),
    .wb_rty_o   (rty),
    .wb_dat_o   (dout),
    .thr_i      (thr_i),
    .thr_o      (thr_o),
    .thr_upd_o  (upd)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write: request in cycle 0, termination expected in cycle 2
  task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat = d;
    @(negedge clk); s_early = ack | err;
    @(posedge clk); #1;
    @(negedge clk); s_early = s_early | ack | err;
    @(posedge clk); #1;
    @(negedge clk); s_ack = ack; s_err = err; s_upd = upd;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); s_upd3 = upd; s_tail = ack | err;
  endtask

  // Read: request in cycle 0, termination expected in cycle 1
  task automatic rd(input logic [2:0] a);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(negedge clk); s_early = ack | err; s_stall0 = stall;
    @(posedge clk); #1;
    @(negedge clk); s_ack = ack; s_err = err; s_dat = dout;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); s_tail = ack | err;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat = '0;
    thr_i[0] = 32'hABCD_0000;
    thr_i[1] = 32'h9999_0000;
    thr_i[2] = 32'h0000_0000;
    thr_i[3] = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   ack, 1'b0);
    chk("rst_err",   err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rty",   rty, 1'b0);
    chk("rst_upd",   upd, 4'h0);
    chk("rst_dat",   dout, 32'h0);
    chk("rst_thr",   thr_o, 128'h0);
    @(posedge clk); #1; rst = 1'b0;

    // read channel 0 and CTRL after reset
    rd(3'd0);
    chk("rd0_stall0", s_stall0, 1'b1);
    chk("rd0_early",  s_early, 1'b0);
    chk("rd0_ack",    s_ack, 1'b1);
    chk("rd0_err",    s_err, 1'b0);
    chk("rd0_dat",    s_dat, 32'hABCD_0000);
    chk("rd0_tail",   s_tail, 1'b0);
    chk("rd0_thr",    thr_o, 128'h0);
    rd(3'd4);
    chk("rdctrl_ack", s_ack, 1'b1);
    chk("rdctrl_dat", s_dat, 32'h2);

    // immediate mode full and partial writes
    wr(3'd1, 4'hF, 32'h1234_5678);
    chk("w1_early", s_early, 1'b0);
    chk("w1_ack",   s_ack, 1'b1);
    chk("w1_upd",   s_upd, 4'b0010);
    chk("w1_upd3",  s_upd3, 4'b0000);
    chk("w1_thr",   thr_o[1], 32'h1234_5678);
    wr(3'd1, 4'h1, 32'hFFFF_FFFF);
    chk("w1b_upd",  s_upd, 4'b0010);
    chk("w1b_thr",  thr_o[1], 32'h1234_56FF);
    rd(3'd1);
    chk("rd1_dat",  s_dat, 32'h9999_56FF);

    // deferred mode
    wr(3'd4, 4'h1, 32'h0);
    chk("imm0_ack", s_ack, 1'b1);
    chk("imm0_upd", s_upd, 4'h0);
    rd(3'd4);
    chk("imm0_rd",  s_dat, 32'h0);
    wr(3'd0, 4'hF, 32'h5);
    chk("d0_upd",   s_upd, 4'h0);
    chk("d0_thr",   thr_o[0], 32'h0);
    wr(3'd2, 4'hF, 32'h7);
    chk("d2_upd",   s_upd, 4'h0);
    chk("d2_thr",   thr_o[2], 32'h0);
    rd(3'd0);
    chk("d0_rd",    s_dat, 32'hABCD_0005);
    wr(3'd4, 4'h1, 32'h1);
    chk("cm_upd",   s_upd, 4'b0101);
    chk("cm_upd3",  s_upd3, 4'b0000);
    chk("cm_thr",   thr_o, {32'h0, 32'h7, 32'h1234_56FF, 32'h5});
    wr(3'd4, 4'h1, 32'h1);
    chk("cm2_upd",  s_upd, 4'h0);

    // raising IMM flushes a dirty channel
    wr(3'd3, 4'hF, 32'hAA);
    chk("d3_thr",   thr_o[3], 32'h0);
    wr(3'd4, 4'h1, 32'h2);
    chk("sw_upd",   s_upd, 4'b1000);
    chk("sw_thr",   thr_o[3], 32'hAA);
    rd(3'd4);
    chk("sw_rd",    s_dat, 32'h2);

    // out-of-range address
    rd(3'd5);
    chk("erd_ack",  s_ack, 1'b0);
    chk("erd_err",  s_err, 1'b1);
    chk("erd_dat",  s_dat, 32'h0);
    wr(3'd5, 4'hF, 32'hFFFF_FFFF);
    chk("ewr_early", s_early, 1'b0);
    chk("ewr_ack",  s_ack, 1'b0);
    chk("ewr_err",  s_err, 1'b1);
    chk("ewr_upd",  s_upd, 4'h0);
    chk("ewr_thr",  thr_o, {32'hAA, 32'h7, 32'h1234_56FF, 32'h5});

    // CTRL write without lane 0 is ignored
    wr(3'd4, 4'hE, 32'h0);
    chk("nosel_ack", s_ack, 1'b1);
    rd(3'd4);
    chk("nosel_rd", s_dat, 32'h2);

    // reset during cycle 1 of a write, with IMM cleared beforehand
    wr(3'd4, 4'h1, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; sel = 4'hF; dat = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_ack",   ack, 1'b0);
    chk("mr_err",   err, 1'b0);
    chk("mr_upd",   upd, 4'h0);
    chk("mr_thr",   thr_o, 128'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mr_ack2",  ack | err, 1'b0);
    rd(3'd4);
    chk("mr_imm",   s_dat, 32'h2);
    rd(3'd0);
    chk("mr_rd0",   s_dat, 32'hABCD_0000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
